rob_multi_commit: RTL
=====================

Name: rob_multi_commit

Overview:
- Parametrised reorder buffer for the Qu back end; generalises the fixed 4-entry, single-retire ROB.
- Features:
  - Configurable depth.
  - NUM_WB completion ports.
  - In-order commit of up to COMMIT_WIDTH entries per cycle.
  - Flush.
- Sits between dispatch (allocation) and the physical RF / busy table (commit writes).

Parameters:
- ROB_DEPTH, 8, number of entries; power of two, ≥2.
- COMMIT_WIDTH, 2, max entries retired per cycle; 1..ROB_DEPTH.
- NUM_WB, 2, number of completion (CDB) ports; ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rob_incr_tail_ptr  in  1  allocate the entry at the tail this cycle.
- rob_alloc_has_dest  in  1  allocating instruction writes a physical register.
- rob_alloc_dest  in  phy_rf_addr_t  destination physical register.
- rob_flush  in  1  synchronous flush of all entries.
- wb_en  in  NUM_WB  per-port completion strobe.
- wb_rob_addr  in  NUM_WB x rob_addr_t  completing entry.
- wb_value  in  NUM_WB x phy_rf_data_t  result value.
- rob_tail_ptr  out  rob_addr_t  address the next allocation receives.
- rob_full  out  1  count == ROB_DEPTH.
- rob_empty  out  1  count == 0.
- rob_count  out  $clog2(ROB_DEPTH)+1  occupied entries.
- phy_rf_wr_en  out  COMMIT_WIDTH  per-slot RF write.
- phy_rf_wr_addr  out  COMMIT_WIDTH x phy_rf_addr_t  RF write address.
- phy_rf_wr_data  out  COMMIT_WIDTH x phy_rf_data_t  RF write data.
- busy_table_wr_en  out  COMMIT_WIDTH  per-slot busy-table write.
- busy_table_wr_addr  out  COMMIT_WIDTH x phy_rf_addr_t  busy-table address.
- busy_table_wr_data  out  COMMIT_WIDTH  always 0 (clear busy).

Behaviour:
- Reset (rst=0, asynchronous, effective immediately, including mid-operation):
  - head, tail, count = 0; all entries have valid = 0 and done = 0.
  - All commit outputs 0; rob_full = 0, rob_empty = 1, rob_tail_ptr = 0.
- Entry state: valid, done, has_dest, dest, value.
- Allocation:
  - If rob_incr_tail_ptr && !rob_full (registered full, no same-cycle bypass from commit): at the edge set entry[tail] to valid=1, done=0, has_dest, dest; tail = (tail+1) mod ROB_DEPTH.
  - Allocation while full is dropped with no state change.
- Completion:
  - For each port i with wb_en[i]: if entry[wb_rob_addr[i]].valid, set done=1 and value=wb_value[i] at the edge.
  - Writes to invalid entries are ignored.
  - Same address on several ports: highest port index wins.
- Commit select (combinational, from registered state):
  - k = number of consecutive valid&done entries starting at head.
  - k is capped at COMMIT_WIDTH and at count; the scan wraps modulo ROB_DEPTH.
- Commit (registered outputs, 1-cycle latency):
  - At the edge, head += k (mod ROB_DEPTH) and committed entries are cleared to valid=0.
  - For slot j<k: phy_rf_wr_en[j] = has_dest, addr = dest, data = value; busy_table_wr_en[j] = has_dest, addr = dest, data = 0.
  - Slots j≥k are driven 0.
  - Slot 0 is always the oldest entry.
  - Entries without a destination retire with write enables low.
- Completion-to-commit timing: an entry completed at edge E commits at edge E+1; its writes are visible from E+1 until E+2.
- Counting: count_next = count + alloc_accepted − k; alloc and commit in the same cycle are both applied.
- Flush:
  - rob_flush=1 at an edge: head = tail = count = 0, all entries invalid, commit outputs 0.
  - Overrides allocation, completion and commit in that cycle.
- Output derivation: rob_full, rob_empty, rob_count and rob_tail_ptr are derived from registers only (no input-to-output combinational path).

Decomposition:
- qu_pkg:
  - rob_addr_t sized $clog2(ROB_DEPTH).
  - phy_rf_addr_t, phy_rf_data_t.
  - rob_entry_t struct {valid, done, has_dest, dest, value}.
- Sub-module rob_commit_select: combinational, takes entry valid/done vectors, head and count; returns k and per-slot entry indices; parametrised by ROB_DEPTH and COMMIT_WIDTH.

Test Plan (ROB_DEPTH=4, COMMIT_WIDTH=2, NUM_WB=2):
- Reset, then 4 allocations with dest 4,5,6,7 → rob_tail_ptr steps 0,1,2,3,0; rob_full=1 after the 4th; a 5th allocation is dropped and rob_count stays 4.
- Complete entries 1 and 0 on ports 0/1 in the same cycle with values 23 and 33 → next cycle phy_rf_wr_en=2'b11, addr {5,4}, data {23,33}, busy_table_wr_data=0; rob_count=2.
- Complete entry 3 only (entry 2 pending) → no commit; then complete entry 2 with value 63 → slot 0 = dest 6 / 63, slot 1 = dest 7; head wraps to 0.
- Four entries done at once → commits 2 then 2 on consecutive cycles; allocation in the second cycle is accepted; rob_count goes 4→2→1.
- Both ports write entry 0 in one cycle (values 10, 20) → committed data = 20.
- rob_flush while holding 3 entries, with simultaneous allocation and completion → rob_count=0, rob_empty=1, no commit writes.
- Assert rst low mid-commit → outputs 0 immediately.

Source files
------------

// File: rtl/qu_pkg.sv
// Shared Qu back-end types: physical register file address/data and the ROB entry record.
package qu_pkg;

  localparam int PHY_RF_ADDR_W = 6;
  localparam int PHY_RF_DATA_W = 32;

  typedef logic [PHY_RF_ADDR_W-1:0] phy_rf_addr_t;
  typedef logic [PHY_RF_DATA_W-1:0] phy_rf_data_t;

  typedef struct packed {
    logic         valid;
    logic         done;
    logic         has_dest;
    phy_rf_addr_t dest;
    phy_rf_data_t value;
  } rob_entry_t;

endpackage

// File: rtl/rob_multi_commit_if.sv
// Dispatch, completion and commit-side signals of the multi-commit reorder buffer.
interface rob_multi_commit_if #(
  parameter int ROB_DEPTH    = 8,
  parameter int COMMIT_WIDTH = 2,
  parameter int NUM_WB       = 2
);
  import qu_pkg::*;

  localparam int ADDR_W = $clog2(ROB_DEPTH);
  localparam int CNT_W  = $clog2(ROB_DEPTH) + 1;

  typedef logic [ADDR_W-1:0] rob_addr_t;

  logic                               rob_incr_tail_ptr;
  logic                               rob_alloc_has_dest;
  phy_rf_addr_t                       rob_alloc_dest;
  logic                               rob_flush;
  logic         [NUM_WB-1:0]          wb_en;
  rob_addr_t    [NUM_WB-1:0]          wb_rob_addr;
  phy_rf_data_t [NUM_WB-1:0]          wb_value;

  rob_addr_t                          rob_tail_ptr;
  logic                               rob_full;
  logic                               rob_empty;
  logic         [CNT_W-1:0]           rob_count;
  logic         [COMMIT_WIDTH-1:0]    phy_rf_wr_en;
  phy_rf_addr_t [COMMIT_WIDTH-1:0]    phy_rf_wr_addr;
  phy_rf_data_t [COMMIT_WIDTH-1:0]    phy_rf_wr_data;
  logic         [COMMIT_WIDTH-1:0]    busy_table_wr_en;
  phy_rf_addr_t [COMMIT_WIDTH-1:0]    busy_table_wr_addr;
  logic         [COMMIT_WIDTH-1:0]    busy_table_wr_data;

  modport master (
    output rob_incr_tail_ptr, rob_alloc_has_dest, rob_alloc_dest, rob_flush,
           wb_en, wb_rob_addr, wb_value,
    input  rob_tail_ptr, rob_full, rob_empty, rob_count,
           phy_rf_wr_en, phy_rf_wr_addr, phy_rf_wr_data,
           busy_table_wr_en, busy_table_wr_addr, busy_table_wr_data
  );

  modport slave (
    input  rob_incr_tail_ptr, rob_alloc_has_dest, rob_alloc_dest, rob_flush,
           wb_en, wb_rob_addr, wb_value,
    output rob_tail_ptr, rob_full, rob_empty, rob_count,
           phy_rf_wr_en, phy_rf_wr_addr, phy_rf_wr_data,
           busy_table_wr_en, busy_table_wr_addr, busy_table_wr_data
  );

endinterface

// File: rtl/rob_commit_select.sv
// Counts the run of valid&done entries starting at head, capped by commit width and occupancy.
module rob_commit_select #(
  parameter int ROB_DEPTH    = 8,
  parameter int COMMIT_WIDTH = 2
) (
  input  logic [ROB_DEPTH-1:0]                            valid,
  input  logic [ROB_DEPTH-1:0]                            done,
  input  logic [$clog2(ROB_DEPTH)-1:0]                    head,
  input  logic [$clog2(ROB_DEPTH):0]                      count,
  output logic [$clog2(COMMIT_WIDTH+1)-1:0]               k,
  output logic [COMMIT_WIDTH-1:0][$clog2(ROB_DEPTH)-1:0]  idx
);

  localparam int ADDR_W = $clog2(ROB_DEPTH);
  localparam int CNT_W  = $clog2(ROB_DEPTH) + 1;

  logic stop;

  // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    k    = '0;
    idx  = '0;
    stop = 1'b0;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      // Index arithmetic truncates to ADDR_W bits, which is the modulo wrap.
      idx[j] = head + ADDR_W'(j);
      if (!stop && (CNT_W'(j) < count) && valid[idx[j]] && done[idx[j]]) begin
        k = k + 1'b1;
      end else begin
        stop = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer with NUM_WB completion ports and in-order retire of up to COMMIT_WIDTH entries per cycle.
module rob_multi_commit
  import qu_pkg::*;
#(
  parameter int ROB_DEPTH    = 8,
  parameter int COMMIT_WIDTH = 2,
  parameter int NUM_WB       = 2
) (
  input  logic               clk,
  input  logic               rst,
  rob_multi_commit_if.slave  rob
);

  localparam int ADDR_W = $clog2(ROB_DEPTH);
  localparam int CNT_W  = $clog2(ROB_DEPTH) + 1;
  localparam int KW     = $clog2(COMMIT_WIDTH + 1);

  typedef logic [ADDR_W-1:0] rob_addr_t;

  rob_entry_t entry_q [ROB_DEPTH];
  rob_entry_t entry_d [ROB_DEPTH];

  rob_addr_t  head_q,  head_d;
  rob_addr_t  tail_q,  tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic         [COMMIT_WIDTH-1:0] wr_en_q,   wr_en_d;
  phy_rf_addr_t [COMMIT_WIDTH-1:0] wr_addr_q, wr_addr_d;
  phy_rf_data_t [COMMIT_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [ROB_DEPTH-1:0]           entry_valid;
  logic [ROB_DEPTH-1:0]           entry_done;
  logic [KW-1:0]                  commit_k;
  rob_addr_t [COMMIT_WIDTH-1:0]   commit_idx;
  logic                           full;
  logic                           alloc_ok;

  always_comb begin
    entry_valid = '0;
    entry_done  = '0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      entry_valid[i] = entry_q[i].valid;
      entry_done[i]  = entry_q[i].done;
    end
  end

  rob_commit_select #(
    .ROB_DEPTH    (ROB_DEPTH),
    .COMMIT_WIDTH (COMMIT_WIDTH)
  ) u_commit_select (
    .valid (entry_valid),
    .done  (entry_done),
    .head  (head_q),
    .count (count_q),
    .k     (commit_k),
    .idx   (commit_idx)
  );

  assign full     = (count_q == CNT_W'(ROB_DEPTH));
  assign alloc_ok = rob.rob_incr_tail_ptr && !full;

  always_comb begin
    entry_d   = entry_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    wr_en_d   = '0;
    wr_addr_d = '0;
    wr_data_d = '0;

    // Ascending port order lets the highest-indexed port win on an address collision.
    for (int i = 0; i < NUM_WB; i++) begin
      if (rob.wb_en[i] && entry_q[rob.wb_rob_addr[i]].valid) begin
        entry_d[rob.wb_rob_addr[i]].done  = 1'b1;
        entry_d[rob.wb_rob_addr[i]].value = rob.wb_value[i];
      end
    end

    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      if (KW'(j) < commit_k) begin
        wr_en_d[j]                    = entry_q[commit_idx[j]].has_dest;
        wr_addr_d[j]                  = entry_q[commit_idx[j]].dest;
        wr_data_d[j]                  = entry_q[commit_idx[j]].value;
        entry_d[commit_idx[j]].valid  = 1'b0;
        entry_d[commit_idx[j]].done   = 1'b0;
      end
    end
    head_d = head_q + ADDR_W'(commit_k);

    // The tail slot is never valid while not full, so it cannot collide with a retiring entry.
    if (alloc_ok) begin
      entry_d[tail_q] = '{valid:    1'b1,
                          done:     1'b0,
                          has_dest: rob.rob_alloc_has_dest,
                          dest:     rob.rob_alloc_dest,
                          value:    '0};
      tail_d = tail_q + 1'b1;
    end
    count_d = count_q + CNT_W'(alloc_ok) - CNT_W'(commit_k);

    if (rob.rob_flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entry_d[i].valid = 1'b0;
        entry_d[i].done  = 1'b0;
      end
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      wr_en_d   = '0;
      wr_addr_d = '0;
      wr_data_d = '0;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      // NOTE: the whole entry array is reset, payload included, so no X ever reaches commit data.
      entry_q   <= '{default: '0};
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      entry_q   <= entry_d;
    end
  end

  assign rob.rob_tail_ptr       = tail_q;
  assign rob.rob_full           = full;
  assign rob.rob_empty          = (count_q == '0);
  assign rob.rob_count          = count_q;
  assign rob.phy_rf_wr_en       = wr_en_q;
  assign rob.phy_rf_wr_addr     = wr_addr_q;
  assign rob.phy_rf_wr_data     = wr_data_q;
  assign rob.busy_table_wr_en   = wr_en_q;
  assign rob.busy_table_wr_addr = wr_addr_q;
  assign rob.busy_table_wr_data = '0;

endmodule
